// File: rtl/sort4_seq.sv
// Four-word batch sorter: loads four words, sorts them with one shared
// compare-swap stage over five clocks, then unloads them smallest first.
module sort4_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int unsigned N_WORDS = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned STEP_W  = 3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [W-1:0]        r_word     [N_WORDS];
  logic [W-1:0]        w_word_nxt [N_WORDS];
  logic [IDX_W-1:0]    w_lo;
  logic [IDX_W-1:0]    w_hi;

  // State, index, step and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_idx   <= IDX_W'(0);
      r_step  <= STEP_W'(0);
      for (int i = 0; i < N_WORDS; i++) r_word[i] <= W'(0);
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_step  <= w_step_nxt;
      for (int i = 0; i < N_WORDS; i++) r_word[i] <= w_word_nxt[i];
    end
  end

  // Next-state logic; the sort network pair is picked by the step counter
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_step_nxt  = r_step;
    for (int i = 0; i < N_WORDS; i++) w_word_nxt[i] = r_word[i];
    w_lo = IDX_W'(0);
    w_hi = IDX_W'(2);

    case (r_step)
      STEP_W'(0): begin w_lo = IDX_W'(0); w_hi = IDX_W'(2); end
      STEP_W'(1): begin w_lo = IDX_W'(1); w_hi = IDX_W'(3); end
      STEP_W'(2): begin w_lo = IDX_W'(0); w_hi = IDX_W'(1); end
      STEP_W'(3): begin w_lo = IDX_W'(2); w_hi = IDX_W'(3); end
      default:    begin w_lo = IDX_W'(1); w_hi = IDX_W'(2); end
    endcase

    case (r_state)
      S_LOAD: begin
        if (in_valid) begin
          w_word_nxt[r_idx] = in_data;
          w_idx_nxt         = r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(3)) begin
            w_state_nxt = S_SORT;
            w_step_nxt  = STEP_W'(0);
          end
        end
      end
      S_SORT: begin
        // Strictly greater only: equal words keep their positions
        if (r_word[w_lo] > r_word[w_hi]) begin
          w_word_nxt[w_lo] = r_word[w_hi];
          w_word_nxt[w_hi] = r_word[w_lo];
        end
        if (r_step == STEP_W'(4)) begin
          w_state_nxt = S_OUT;
          w_idx_nxt   = IDX_W'(0);
          w_step_nxt  = STEP_W'(0);
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_idx_nxt = r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(3)) w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = IDX_W'(0);
        w_step_nxt  = STEP_W'(0);
      end
    endcase
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_LOAD);
  assign out_data  = r_word[r_idx];

endmodule
